// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer. Fetch stays decoupled
// from stalls: a fetch accepted during a stall is parked in the skid buffer.
module if_id_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [15:0] RST_PC    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] PC_plus_two_in,
    input  logic        fetch_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] PC_plus_two_out,
    output logic        valid_out,
    output logic        fetch_ready
);

    typedef enum logic {SKID_EMPTY = 1'b0, SKID_FULL = 1'b1} skid_e;

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    skid_e       skid_q, skid_d;
    logic        accept;

    // Ready depends only on skid occupancy so fetch never sees a stall path.
    assign fetch_ready = (skid_q == SKID_EMPTY);
    assign accept      = fetch_valid & fetch_ready;

    always_comb begin
        instr_d      = instr_q;
        pc_d         = pc_q;
        vld_d        = vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_d       = skid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc_d    = RST_PC;
            vld_d   = 1'b0;
            skid_d  = SKID_EMPTY;
        end else if (stall) begin
            if (accept) begin
                skid_instr_d = instr_in;
                skid_pc_d    = PC_plus_two_in;
                skid_d       = SKID_FULL;
            end
        end else if (skid_q == SKID_FULL) begin
            instr_d = skid_instr_q;
            pc_d    = skid_pc_q;
            vld_d   = 1'b1;
            skid_d  = SKID_EMPTY;
        end else if (accept) begin
            instr_d = instr_in;
            pc_d    = PC_plus_two_in;
            vld_d   = 1'b1;
        end else begin
            // Bubble keeps the last PC+2 so decode sees a stable value.
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q      <= NOP_INSTR;
            pc_q         <= RST_PC;
            vld_q        <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= RST_PC;
            skid_q       <= SKID_EMPTY;
        end else begin
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            vld_q        <= vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_q       <= skid_d;
        end
    end

    assign instr_out       = instr_q;
    assign PC_plus_two_out = pc_q;
    assign valid_out       = vld_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: directed per-cycle vectors push the expected
// post-edge state; a monitor pops and compares one entry after each edge.
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst, fetch_valid, stall, flush;
    logic [15:0] instr_in, PC_plus_two_in;
    logic [15:0] instr_out, PC_plus_two_out;
    logic        valid_out, fetch_ready;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        vld;
        logic        rdy;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 0;

    if_id_reg #(.NOP_INSTR(16'h0800), .RST_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_in       (instr_in),
        .PC_plus_two_in (PC_plus_two_in),
        .fetch_valid    (fetch_valid),
        .stall          (stall),
        .flush          (flush),
        .instr_out      (instr_out),
        .PC_plus_two_out(PC_plus_two_out),
        .valid_out      (valid_out),
        .fetch_ready    (fetch_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a new decode-stage state.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, ".instr"}, instr_out, e.instr);
                chk({e.tag, ".pc"}, PC_plus_two_out, e.pc);
                chk({e.tag, ".valid"}, {15'd0, valid_out}, {15'd0, e.vld});
                chk({e.tag, ".ready"}, {15'd0, fetch_ready}, {15'd0, e.rdy});
            end
        end
    end

    task automatic step(input string tag, input logic r, input logic fv,
                        input logic [15:0] ins, input logic [15:0] pc,
                        input logic st, input logic fl,
                        input logic [15:0] ei, input logic [15:0] ep,
                        input logic ev, input logic er);
        exp_t e;
        @(negedge clk);
        rst = r; fetch_valid = fv; instr_in = ins; PC_plus_two_in = pc;
        stall = st; flush = fl;
        e.instr = ei; e.pc = ep; e.vld = ev; e.rdy = er; e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instr_in = 16'h0; PC_plus_two_in = 16'h0;
        //            tag        rst fv ins       pc        st fl  exp_instr exp_pc   v  rdy
        step("rst",        1, 1, 16'hC123, 16'h1111, 0, 0, 16'h0800, 16'h0000, 0, 1);
        step("s1",         0, 1, 16'h4001, 16'h0002, 0, 0, 16'h4001, 16'h0002, 1, 1);
        step("s2",         0, 1, 16'h4002, 16'h0004, 0, 0, 16'h4002, 16'h0004, 1, 1);
        step("s3",         0, 1, 16'h4003, 16'h0006, 0, 0, 16'h4003, 16'h0006, 1, 1);
        step("re1",        0, 1, 16'h4001, 16'h0002, 0, 0, 16'h4001, 16'h0002, 1, 1);
        step("stall1",     0, 1, 16'h4002, 16'h0004, 1, 0, 16'h4001, 16'h0002, 1, 0);
        step("stall2",     0, 1, 16'h4003, 16'h0006, 1, 0, 16'h4001, 16'h0002, 1, 0);
        step("stall3",     0, 1, 16'h4003, 16'h0006, 1, 0, 16'h4001, 16'h0002, 1, 0);
        step("drain",      0, 1, 16'h4003, 16'h0006, 0, 0, 16'h4002, 16'h0004, 1, 1);
        step("next",       0, 1, 16'h4003, 16'h0006, 0, 0, 16'h4003, 16'h0006, 1, 1);
        step("fill",       0, 1, 16'h5001, 16'h0008, 1, 0, 16'h4003, 16'h0006, 1, 0);
        step("flush_st",   0, 1, 16'h5002, 16'h0009, 1, 1, 16'h0800, 16'h0000, 0, 1);
        step("post_fl",    0, 1, 16'h5003, 16'h000A, 0, 0, 16'h5003, 16'h000A, 1, 1);
        step("bub1",       0, 0, 16'hDEAD, 16'hBEEF, 0, 0, 16'h0800, 16'h000A, 0, 1);
        step("bub2",       0, 0, 16'hFACE, 16'hCAFE, 0, 0, 16'h0800, 16'h000A, 0, 1);
        step("resume",     0, 1, 16'h6001, 16'h000C, 0, 0, 16'h6001, 16'h000C, 1, 1);
        step("flush_fv",   0, 1, 16'h6F00, 16'h000E, 0, 1, 16'h0800, 16'h0000, 0, 1);
        step("after_ffv",  0, 0, 16'h6F00, 16'h000E, 0, 0, 16'h0800, 16'h0000, 0, 1);
        step("pre_rst",    0, 1, 16'h7001, 16'h0010, 1, 0, 16'h0800, 16'h0000, 0, 0);
        step("rst_stall",  1, 1, 16'h7001, 16'h0010, 1, 0, 16'h0800, 16'h0000, 0, 1);
        step("post_rst",   0, 1, 16'h7002, 16'h0012, 0, 0, 16'h7002, 16'h0012, 1, 1);
        step("tail_bub",   0, 0, 16'h7003, 16'h0014, 0, 0, 16'h0800, 16'h0012, 0, 1);
        @(negedge clk);
        fetch_valid = 1'b0;
        stim_done = 1;
    end

    initial begin
        int waited;
        wait (stim_done);
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
